// File: rtl/gate_tt_if.sv
// Stimulus/response bundle between a truth-table checker and its controller.
// The checker drives the gate inputs and status; the controller drives
// start/func_sel, and the gate under test drives y.
interface gate_tt_if;
    logic       start;
    logic [2:0] func_sel;
    logic       y;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    // Controller / environment side
    modport master (
        output start, func_sel, y,
        input  a, b, busy, done, pass, err_count, fail_vec
    );

    // Checker side
    modport slave (
        input  start, func_sel, y,
        output a, b, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_tt_checker.sv
// Sequential truth-table driver/checker for a 2-input gate. Applies the
// vectors 00, 01, 10, 11 in turn, waits SETTLE cycles on each, samples y and
// compares it against the golden function latched at start.
module gate_tt_checker #(
    parameter int unsigned SETTLE = 2   // legal range 1..15
) (
    input  logic          clk,
    input  logic          rst,
    gate_tt_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_next;
    logic [2:0] fsel;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       a_q, b_q;
    logic       busy_q, done_q, pass_q;
    logic [2:0] err_q;
    logic [3:0] fail_q;

    logic       accept;     // start taken this edge
    logic       sample;     // y is sampled this edge
    logic       exp_y;
    logic       mismatch;

    // Golden response for the current vector under the latched function
    always_comb begin
        unique case (fsel)
            3'd0:    exp_y =   a_q & b_q;
            3'd1:    exp_y =   a_q | b_q;
            3'd2:    exp_y = ~(a_q & b_q);
            3'd3:    exp_y = ~(a_q | b_q);
            3'd4:    exp_y =   a_q ^ b_q;
            3'd5:    exp_y = ~(a_q ^ b_q);
            3'd6:    exp_y =  ~a_q;
            default: exp_y =   a_q;
        endcase
    end

    assign mismatch = (bus.y != exp_y);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        // NOTE: clocked state uses non-blocking assignment so every register
        // sees the pre-edge values of the others, regardless of block order.
        else     state <= state_next;
    end

    // Next-state decode and per-edge control strobes
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_next = state;
        accept     = 1'b0;
        sample     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == SETTLE_LAST) begin
                    sample = 1'b1;
                    if (idx == 2'd3) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Vector sequencing, sampling and result accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsel   <= 3'd0;
            idx    <= 2'd0;
            cnt    <= 4'd0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= 3'd0;
            fail_q <= 4'd0;
        end else if (accept) begin
            fsel   <= bus.func_sel;
            idx    <= 2'd0;
            cnt    <= 4'd0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= 3'd0;
            fail_q <= 4'd0;
        end else if (state == WAIT) begin
            if (!sample) begin
                cnt <= cnt + 4'd1;
            end else begin
                if (mismatch) begin
                    fail_q[idx] <= 1'b1;
                    err_q       <= err_q + 3'd1;
                end
                if (idx != 2'd3) begin
                    idx        <= idx + 2'd1;
                    {a_q, b_q} <= idx + 2'd1;
                    cnt        <= 4'd0;
                end else begin
                    // a/b stay at 11 until the next start
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (err_q == 3'd0) && !mismatch;
                end
            end
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker with SETTLE=2. A behavioural gate model
// (correct NAND, stuck-at-0, or XNOR) drives y from the checker's a/b.
module tb_gate_tt_checker;

    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;         // 0: NAND model, 1: y stuck at 0, 2: XNOR model
    int   errors = 0;
    int   checks = 0;
    int   edges;

    gate_tt_if bus ();

    gate_tt_checker #(.SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.y = (mode == 0) ? ~(bus.a & bus.b) :
                   (mode == 1) ? 1'b0 :
                                 ~(bus.a ^ bus.b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present start with the given function for exactly one rising edge (E0);
    // returns at E0+#1.
    task automatic do_start(input logic [2:0] fs);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.func_sel = fs;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges after E0 until done is seen; -1 if it never comes.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_final(input string tag, input logic p, input logic [2:0] ec,
                               input logic [3:0] fv);
        check({tag, "_pass"}, bus.pass, p);
        check({tag, "_err"},  bus.err_count, ec);
        check({tag, "_fvec"}, bus.fail_vec, fv);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_ab"},   {bus.a, bus.b}, 2'b11);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.func_sel = 3'd0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_ab",   {bus.a, bus.b}, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_pass", bus.pass, 1'b0);
        check("rst_err",  bus.err_count, 3'd0);
        check("rst_fvec", bus.fail_vec, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: NAND against a correct NAND, vector timing edge by edge
        mode = 0;
        do_start(3'd2);
        check("t1_e0_ab",   {bus.a, bus.b}, 2'b00);
        check("t1_e0_busy", bus.busy, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t1_ab_e%0d", k), {bus.a, bus.b}, (k < 8) ? k / SETTLE : 3);
            check($sformatf("t1_done_e%0d", k), bus.done, k == 8);
        end
        check_final("t1", 1'b1, 3'd0, 4'b0000);

        // 2: NAND against y stuck at 0: only vector 11 matches
        mode = 1;
        do_start(3'd2);
        wait_done(edges);
        check("t2_lat", edges, 8);
        check_final("t2", 1'b0, 3'd3, 4'b0111);

        // 3: AND golden against a NAND: every vector mismatches
        mode = 0;
        do_start(3'd0);
        wait_done(edges);
        check("t3_lat", edges, 8);
        check_final("t3", 1'b0, 3'd4, 4'b1111);

        // 6: restart from a failed DONE with XNOR; results clear at E0
        mode = 2;
        do_start(3'd5);
        check("t6_e0_err",  bus.err_count, 3'd0);
        check("t6_e0_fvec", bus.fail_vec, 4'd0);
        check("t6_e0_done", bus.done, 1'b0);
        check("t6_e0_pass", bus.pass, 1'b0);
        check("t6_e0_ab",   {bus.a, bus.b}, 2'b00);
        wait_done(edges);
        check("t6_lat", edges, 8);
        check_final("t6", 1'b1, 3'd0, 4'b0000);

        // 4: start pulse and func_sel change at E0+3 must not disturb the run
        mode = 0;
        do_start(3'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.func_sel = 3'd0;
        @(posedge clk);             // E0+3
        #1;
        bus.start = 1'b0;
        check("t4_e3_ab", {bus.a, bus.b}, 2'b01);
        edges = -1;
        for (int i = 4; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                edges = i;
                break;
            end
        end
        check("t4_lat", edges, 8);
        check_final("t4", 1'b1, 3'd0, 4'b0000);

        // 5: async reset between edges during vector 2, then a clean run
        mode = 1;
        do_start(3'd2);
        repeat (4) @(posedge clk);  // vector 2 applied at E0+4
        #3;
        check("t5_pre_ab", {bus.a, bus.b}, 2'b10);
        rst = 1'b1;
        #1;
        check("t5_rst_ab",   {bus.a, bus.b}, 2'b00);
        check("t5_rst_busy", bus.busy, 1'b0);
        check("t5_rst_done", bus.done, 1'b0);
        check("t5_rst_err",  bus.err_count, 3'd0);
        check("t5_rst_fvec", bus.fail_vec, 4'd0);
        @(negedge clk);
        rst  = 1'b0;
        mode = 0;
        do_start(3'd2);
        wait_done(edges);
        check("t5_lat", edges, 8);
        check_final("t5", 1'b1, 3'd0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Sequential truth-table driver/checker: the stimulus-and-response end of the 2-input gate interface (inputs a, b; output y).
- Drives all four input vectors into a gate under test in the order 00, 01, 10, 11, waits a programmable settle time, samples y and compares it against a selected golden function.
- Reports per-vector mismatches, an error count and pass/fail. Used for in-hardware self-check of the basic-gate library, replacing $monitor-based inspection.

Parameters:
- SETTLE, 2: cycles between driving a vector and sampling y; legal range 1..15 (4-bit counter).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  begin a check run; sampled on the clock edge
- func_sel  input  3  golden function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a
- y  input  1  output of the gate under test
- a  output  1  gate input a (registered)
- b  output  1  gate input b (registered)
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until the next accepted start or reset
- pass  output  1  high when done=1 and err_count=0
- err_count  output  3  number of mismatching vectors, 0..4
- fail_vec  output  4  bit i set if vector i ({a,b}=i) mismatched

Behaviour:
- Reset (async, rst=1): state IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, idx=0, cnt=0. Reset mid-run aborts the run immediately; no partial results are retained.
- States: IDLE, WAIT, DONE.
- Start acceptance:
  - IDLE or DONE with start=1 at edge E0: latch func_sel into fsel; idx<=0; {a,b}<=00; cnt<=0; err_count<=0; fail_vec<=0; done<=0; pass<=0; busy<=1; state<=WAIT.
  - start is ignored while in WAIT.
  - func_sel changes after E0 have no effect on the current run.
- WAIT, on each edge:
  - If cnt != SETTLE-1: cnt<=cnt+1.
  - If cnt == SETTLE-1: sample y and compute exp = golden(fsel, a, b).
    - On mismatch (y != exp): fail_vec[idx]<=1, err_count<=err_count+1.
    - If idx<3: idx<=idx+1, {a,b}<=idx+1, cnt<=0.
    - If idx==3: state<=DONE, busy<=0, done<=1, pass<=(no mismatch across all four vectors, including the final one).
- Timing:
  - Vector i is applied from edge E0+i*SETTLE.
  - Vector i is sampled at edge E0+(i+1)*SETTLE.
  - done rises at edge E0+4*SETTLE. For SETTLE=1, the vector and its sample occupy one cycle each.
- DONE: outputs held. a and b hold 11 until the next start. start=1 restarts exactly as from IDLE, clearing results on that edge.
- Golden function: exp is combinational on the registered a, b and the latched fsel. Codes 6 and 7 ignore b.
- err_count saturates naturally at 4 (max four vectors); no wrap.

Test Plan:
- SETTLE=2, func_sel=2, y driven by a correct NAND model -> a,b sequence 00,01,10,11 changing every 2 cycles; done=1 at E0+8; pass=1; err_count=0; fail_vec=0000; busy=0.
- func_sel=2, y stuck at 0 -> err_count=3, fail_vec=0111, pass=0 (vector 11 expects 0 and matches).
- func_sel=0 (AND), y from a NAND model -> err_count=4, fail_vec=1111, pass=0.
- Pulse start and toggle func_sel at E0+3 while busy -> run unaffected; done still at E0+8 with results for the originally latched function.
- Assert rst between edges during vector 2 -> a=b=0, busy=0, done=0, err_count=0, fail_vec=0 immediately, without waiting for a clock edge. A subsequent start runs a full clean check.
- After a failing run (done=1), start with func_sel=5 and an XNOR model -> err_count and fail_vec cleared at E0, final pass=1, err_count=0.
